// File: rtl/ps2_autotype.sv
// ASCII-to-PS/2 Set-2 autotyper: FIFO-buffered characters become timed press/release events.
// Define PS2_AUTOTYPE_CURSOR_EN to map 0x80-0x83 onto the extended cursor keys.
module ps2_autotype #(
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_CYCLES = 560000,
  parameter int GAP_CYCLES  = 280000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [7:0]  char_in,
  input  logic        char_valid,
  output logic        char_ready,
  output logic [65:0] ps2_key,
  output logic        busy,
  output logic [7:0]  drop_cnt
);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int TMAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [7:0] RSHIFT = 8'h59;

  typedef enum logic [2:0] {IDLE, DECODE, SHIFT_DN, KEY_DN, KEY_UP, SHIFT_UP, WAIT} state_e;
  typedef struct packed {
    logic       mapped;
    logic       shift;
    logic       ext;
    logic [7:0] code;
  } map_t;

  function automatic map_t lut(input logic [7:0] c);
    map_t       m;
    logic [7:0] lc;
    m = '0;
    m.mapped = 1'b1;
    lc = c;
    // Upper-case letters share the lower-case scancode, wrapped in shift.
    if (c >= 8'h41 && c <= 8'h5A) begin
      lc = c | 8'h20;
      m.shift = 1'b1;
    end
    case (lc)
      "a": m.code = 8'h1C; "b": m.code = 8'h32; "c": m.code = 8'h21; "d": m.code = 8'h23;
      "e": m.code = 8'h24; "f": m.code = 8'h2B; "g": m.code = 8'h34; "h": m.code = 8'h33;
      "i": m.code = 8'h43; "j": m.code = 8'h3B; "k": m.code = 8'h42; "l": m.code = 8'h4B;
      "m": m.code = 8'h3A; "n": m.code = 8'h31; "o": m.code = 8'h44; "p": m.code = 8'h4D;
      "q": m.code = 8'h15; "r": m.code = 8'h2D; "s": m.code = 8'h1B; "t": m.code = 8'h2C;
      "u": m.code = 8'h3C; "v": m.code = 8'h2A; "w": m.code = 8'h1D; "x": m.code = 8'h22;
      "y": m.code = 8'h35; "z": m.code = 8'h1A;
      "0": m.code = 8'h45; "1": m.code = 8'h16; "2": m.code = 8'h1E; "3": m.code = 8'h26;
      "4": m.code = 8'h25; "5": m.code = 8'h2E; "6": m.code = 8'h36; "7": m.code = 8'h3D;
      "8": m.code = 8'h3E; "9": m.code = 8'h46;
      " ":          m.code = 8'h29;
      8'h0D, 8'h0A: m.code = 8'h5A;
      8'h08:        m.code = 8'h66;
      ".": m.code = 8'h49; ",": m.code = 8'h41; "/": m.code = 8'h4A; ";": m.code = 8'h4C;
      8'h27: m.code = 8'h52; "-": m.code = 8'h4E; "=": m.code = 8'h55;
      ">": begin m.code = 8'h49; m.shift = 1'b1; end
      "<": begin m.code = 8'h41; m.shift = 1'b1; end
      "?": begin m.code = 8'h4A; m.shift = 1'b1; end
      ":": begin m.code = 8'h4C; m.shift = 1'b1; end
      8'h22: begin m.code = 8'h52; m.shift = 1'b1; end
      "_": begin m.code = 8'h4E; m.shift = 1'b1; end
      "+": begin m.code = 8'h55; m.shift = 1'b1; end
`ifdef PS2_AUTOTYPE_CURSOR_EN
      8'h80: begin m.code = 8'h6B; m.ext = 1'b1; end
      8'h81: begin m.code = 8'h74; m.ext = 1'b1; end
      8'h82: begin m.code = 8'h75; m.ext = 1'b1; end
      8'h83: begin m.code = 8'h72; m.ext = 1'b1; end
`endif
      default: m.mapped = 1'b0;
    endcase
    return m;
  endfunction

  state_e                      state_q, state_d, ret_q, ret_d, act;
  logic [TW-1:0]               timer_q, timer_d;
  logic [65:0]                 key_q, key_d;
  logic [7:0]                  drop_q, drop_d;
  map_t                        dec_q, dec_d;
  logic [FIFO_DEPTH-1:0][7:0]  mem_q, mem_d;
  logic [PW-1:0]               wr_q, wr_d, rd_q, rd_d;
  logic [PW:0]                 cnt_q, cnt_d;
  logic                        push, pop, ev_fire, ev_ext, ev_rel;
  logic [7:0]                  ev_code;

  assign char_ready = (cnt_q != (PW+1)'(FIFO_DEPTH));
  assign busy       = (state_q != IDLE) || (cnt_q != '0);
  assign ps2_key    = key_q;
  assign drop_cnt   = drop_q;

  always_comb begin
    state_d = state_q; ret_d = ret_q; timer_d = timer_q; key_d = key_q;
    drop_d = drop_q; dec_d = dec_q; mem_d = mem_q;
    wr_d = wr_q; rd_d = rd_q; cnt_d = cnt_q;
    ev_fire = 1'b0; ev_ext = 1'b0; ev_rel = 1'b0; ev_code = '0;

    // Emission happens on the edge that leaves DECODE or an expired WAIT, so the
    // emit states act as actions rather than resting states.
    act = state_q;
    if (state_q == DECODE && dec_q.mapped) act = dec_q.shift ? SHIFT_DN : KEY_DN;
    else if (state_q == WAIT && timer_q == '0) act = ret_q;

    push = char_valid && char_ready;
    pop  = (act == IDLE) && (cnt_q != '0);

    case (act)
      IDLE: begin
        state_d = pop ? DECODE : IDLE;
        if (pop) dec_d = lut(mem_q[rd_q]);
      end
      DECODE: begin
        state_d = IDLE;
        if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
      end
      SHIFT_DN: begin
        ev_fire = 1'b1; ev_code = RSHIFT;
        timer_d = TW'(GAP_CYCLES); ret_d = KEY_DN;
      end
      KEY_DN: begin
        ev_fire = 1'b1; ev_code = dec_q.code; ev_ext = dec_q.ext;
        timer_d = TW'(HOLD_CYCLES); ret_d = KEY_UP;
      end
      KEY_UP: begin
        ev_fire = 1'b1; ev_rel = 1'b1; ev_code = dec_q.code; ev_ext = dec_q.ext;
        timer_d = TW'(GAP_CYCLES); ret_d = dec_q.shift ? SHIFT_UP : IDLE;
      end
      SHIFT_UP: begin
        ev_fire = 1'b1; ev_rel = 1'b1; ev_code = RSHIFT;
        timer_d = TW'(GAP_CYCLES); ret_d = IDLE;
      end
      WAIT:    timer_d = timer_q - TW'(1);
      default: state_d = IDLE;
    endcase

    if (ev_fire) begin
      state_d       = WAIT;
      key_d         = '0;
      key_d[64]     = ~key_q[64];
      key_d[7:0]    = ev_code;
      if (ev_rel) begin
        key_d[15:8]  = 8'hF0;
        key_d[23:16] = ev_ext ? 8'hE0 : 8'h00;
      end else begin
        key_d[15:8]  = ev_ext ? 8'hE0 : 8'h00;
      end
    end

    if (push) begin
      mem_d[wr_q] = char_in;
      wr_d        = wr_q + PW'(1);
    end
    if (pop) rd_d = rd_q + PW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (PW+1)'(1);
      2'b01:   cnt_d = cnt_q - (PW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q <= IDLE; ret_q <= IDLE; timer_q <= '0; key_q <= '0;
      drop_q <= '0; dec_q <= '0; mem_q <= '0;
      wr_q <= '0; rd_q <= '0; cnt_q <= '0;
    end else begin
      state_q <= state_d; ret_q <= ret_d; timer_q <= timer_d; key_q <= key_d;
      drop_q <= drop_d; dec_q <= dec_d; mem_q <= mem_d;
      wr_q <= wr_d; rd_q <= rd_d; cnt_q <= cnt_d;
    end
  end
endmodule
